ifetch_unit: RTL and testbench
==============================

# ifetch_unit

Instruction-fetch front end wrapped around the PC register. It consumes the current PC (register `q`) and drives the register's `d` (next PC) and `en` (hold) inputs. It runs a req/ack transaction on the instruction-memory port and presents one fetched instruction, with its PC, to decode over a valid/ready handshake. Branch and jump redirects enter here and squash any fetch already in flight.

## Interface
Parameters:
- `WIDTH`, 32, address/PC width
- `ILEN`, 32, instruction width; PC increment is `ILEN/8`

Ports:
- `clk`  in  1  clock; all state updates on the rising edge
- `reset_n`  in  1  one clock; reset is asynchronous and active-low
- `pc`  in  WIDTH  current PC from the PC register `q`
- `pc_next`  out  WIDTH  to the PC register `d`
- `pc_stall`  out  1  to the PC register `en`; 1 = hold the PC
- `redirect`  in  1  branch/jump taken this cycle
- `redirect_pc`  in  WIDTH  redirect target
- `imem_req`  out  1  memory request; held until `imem_ack`
- `imem_addr`  out  WIDTH  request address; stable while `imem_req` is held
- `imem_ack`  in  1  response valid this cycle; `imem_rdata` is valid with it
- `imem_rdata`  in  ILEN  fetched word
- `if_valid`  out  1  output buffer holds an instruction
- `if_ready`  in  1  decode accepts this cycle
- `if_instr`  out  ILEN  buffered instruction
- `if_pc`  out  WIDTH  PC of `if_instr`
- `if_fault`  out  1  misaligned-PC marker; tied 0 unless the macro is defined

## Operation
- `buf_free = !if_valid || if_ready`.
- FSM states:
  - IDLE: `imem_req = buf_free`, `imem_addr = pc`. On ack, capture the word and stay in IDLE. With no ack, latch `addr_q = pc` and go to REQ.
  - REQ: `imem_req = 1`, `imem_addr = addr_q`. On ack, go to IDLE. The buffer is always empty in REQ, so the response is always accepted.
  - DROP: same outputs as REQ. On ack, discard the response and go to IDLE.
  - FAULT: exists only with the macro. No request is issued. The state is left only by `redirect`.
- Accepted ack:
  - Buffer loads `{imem_rdata, imem_addr}`; `if_valid` becomes 1 next cycle.
  - `pc_stall = 0` and `pc_next = pc + ILEN/8` (modulo 2^WIDTH) in the ack cycle.
- In all other non-redirect cycles: `pc_stall = 1` and `pc_next = pc`.
- The buffer clears when `if_valid && if_ready` and no load occurs in the same cycle. A simultaneous drain and load replaces the entry.
- `redirect` has top priority over all other events:
  - Drives `pc_next = redirect_pc` and `pc_stall = 0`.
  - Clears the buffer next cycle.
  - Discards any ack arriving in the same cycle.
  - Outstanding request without ack (IDLE with req, REQ, or DROP): next state is DROP.
  - Otherwise: next state is IDLE.
- `imem_req` is forced to 0 while `reset_n = 0`.
- Reset values: state IDLE, `if_valid`, `if_instr`, `if_pc`, `if_fault` and `addr_q` all 0.

## Timing
- Ack at cycle t → `if_valid`/`if_instr` at t+1; PC register updates at the t edge.
- `pc_next`, `pc_stall` and `imem_req` are combinational from state, `imem_ack`, `redirect`, `if_ready`. There is no path from `imem_rdata` to any of these.
- Zero-wait memory with `if_ready = 1` gives 1 instruction per cycle.
- An N-wait-state response gives 1 instruction per N+1 cycles.
- Reset deasserted → request at `pc` in the first clock cycle.

## Configuration
- `IFETCH_ALIGN_CHECK_EN`:
  - Defined: in IDLE with `buf_free` and `pc[1:0] != 0`, no request is issued. The buffer loads `if_instr = 0`, `if_fault = 1`, `if_pc = pc`. `pc_stall = 1` and the FSM enters FAULT. Decode sees the faulting entry once.
  - Undefined: no check, no FAULT state, `if_fault` constant 0.

## Structure
- Package `ifetch_pkg`: state enum typedef (IDLE, REQ, DROP, FAULT) and the `ILEN/8` increment constant.
- One sub-module, `ifetch_buf`: single-entry output register with load/drain/flush and the `if_*` outputs.
- The FSM and next-PC mux live in `ifetch_unit`.

## Test plan
1. Reset with `pc = 0x0`, then release; `imem_ack` in the same cycle with rdata `0x00000013` → `imem_addr = 0x0`, `pc_next = 0x4`, `pc_stall = 0`; next cycle `if_valid = 1`, `if_instr = 0x13`, `if_pc = 0x0`.
2. Zero-wait streaming with `if_ready = 1` → `if_pc` = 0x0, 0x4, 0x8, 0xC on consecutive cycles.
3. Ack delayed 3 cycles → `imem_addr` stable, `pc_stall = 1` for 3 cycles, exactly one `if_valid` beat.
4. `if_ready = 0` while the buffer is full → `imem_req = 0`, `pc_stall = 1`, `if_instr` unchanged; raising `if_ready` resumes with a request at the next PC.
5. `redirect` with `redirect_pc = 0x100` in REQ; ack 2 cycles later with `0xDEADBEEF` → no `if_valid` for that word; next request has `imem_addr = 0x100`.
6. With `IFETCH_ALIGN_CHECK_EN`, `pc = 0x6` → no `imem_req`; `if_valid = 1`, `if_fault = 1`, `if_pc = 0x6`; stalls until `redirect` to 0x8, after which fetching resumes at 0x8.

Source files
------------

// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package ifetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_DROP  = 2'd2,
    ST_FAULT = 2'd3
  } ifetch_state_e;

  localparam int unsigned IFETCH_ILEN_DFLT = 32;

  // Byte distance between consecutive instructions.
  function automatic int unsigned pc_inc(input int unsigned ilen);
    return ilen / 8;
  endfunction

endpackage

// File: rtl/ifetch_buf.sv
// Single-entry output register between fetch and decode, with load, drain and flush.
module ifetch_buf #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned ILEN  = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic             flush,
  input  logic [ILEN-1:0]  load_instr,
  input  logic [WIDTH-1:0] load_pc,
  input  logic             load_fault,
  input  logic             if_ready,
  output logic             if_valid,
  output logic [ILEN-1:0]  if_instr,
  output logic [WIDTH-1:0] if_pc,
  output logic             if_fault
);

  logic             valid_q, valid_d;
  logic [ILEN-1:0]  instr_q, instr_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic             fault_q, fault_d;

  // Flush beats load; a load in the drain cycle replaces the entry.
  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    fault_d = fault_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      instr_d = load_instr;
      pc_d    = load_pc;
      fault_d = load_fault;
    end else if (valid_q && if_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      instr_q <= '0;
      pc_q    <= '0;
      fault_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
      fault_q <= fault_d;
    end
  end

  assign if_valid = valid_q;
  assign if_instr = instr_q;
  assign if_pc    = pc_q;
  assign if_fault = fault_q;

endmodule

// File: rtl/ifetch_unit.sv
// Instruction-fetch front end: fetch FSM, next-PC mux and decode output buffer.
// Optional misaligned-PC trap enabled by defining IFETCH_ALIGN_CHECK_EN.
module ifetch_unit
  import ifetch_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned ILEN  = IFETCH_ILEN_DFLT
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_next,
  output logic             pc_stall,
  input  logic             redirect,
  input  logic [WIDTH-1:0] redirect_pc,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_ack,
  input  logic [ILEN-1:0]  imem_rdata,
  output logic             if_valid,
  input  logic             if_ready,
  output logic [ILEN-1:0]  if_instr,
  output logic [WIDTH-1:0] if_pc,
  output logic             if_fault
);

  localparam int unsigned INC = pc_inc(ILEN);

  ifetch_state_e    state_q, state_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic             buf_free;
  logic             misalign;
  logic             req_c;
  logic             load;
  logic             load_fault;
  logic [ILEN-1:0]  load_instr;

  assign buf_free = !if_valid || if_ready;

`ifdef IFETCH_ALIGN_CHECK_EN
  assign misalign = (pc[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  // Next state, memory request and next-PC selection.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    req_c      = 1'b0;
    imem_addr  = addr_q;
    pc_next    = pc;
    pc_stall   = 1'b1;
    load       = 1'b0;
    load_fault = 1'b0;
    case (state_q)
      ST_IDLE: begin
        imem_addr = pc;
        if (buf_free && misalign) begin
          if (!redirect) begin
            load       = 1'b1;
            load_fault = 1'b1;
            state_d    = ST_FAULT;
          end
        end else if (buf_free) begin
          req_c = 1'b1;
          if (imem_ack) begin
            if (!redirect) begin
              load     = 1'b1;
              pc_stall = 1'b0;
              pc_next  = pc + WIDTH'(INC);
            end
          end else begin
            addr_d  = pc;
            state_d = redirect ? ST_DROP : ST_REQ;
          end
        end
      end
      ST_REQ, ST_DROP: begin
        req_c = 1'b1;
        if (imem_ack) begin
          state_d = ST_IDLE;
          if ((state_q == ST_REQ) && !redirect) begin
            load     = 1'b1;
            pc_stall = 1'b0;
            pc_next  = pc + WIDTH'(INC);
          end
        end else if (redirect) begin
          state_d = ST_DROP;
        end
      end
`ifdef IFETCH_ALIGN_CHECK_EN
      ST_FAULT: begin
        if (redirect) state_d = ST_IDLE;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
    if (redirect) begin
      pc_next  = redirect_pc;
      pc_stall = 1'b0;
    end
  end

  assign imem_req   = req_c && reset_n;
  assign load_instr = load_fault ? '0 : imem_rdata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  ifetch_buf #(
    .WIDTH (WIDTH),
    .ILEN  (ILEN)
  ) u_buf (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (load),
    .flush      (redirect),
    .load_instr (load_instr),
    .load_pc    (imem_addr),
    .load_fault (load_fault),
    .if_ready   (if_ready),
    .if_valid   (if_valid),
    .if_instr   (if_instr),
    .if_pc      (if_pc),
    .if_fault   (if_fault)
  );

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: directed scenarios then random traffic against a transaction-level model.
// Fault scenario runs only when IFETCH_ALIGN_CHECK_EN is defined.
module tb_ifetch_unit;

  logic        clk;
  logic        reset_n;
  logic [31:0] pc;
  logic [31:0] pc_next;
  logic        pc_stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_fault;

  int n_checks;
  int n_errors;

  // memory / transaction tracking
  logic        busy;
  logic        stale;
  logic [31:0] tx_addr;
  int unsigned wait_left;

  // expected decode buffer and program order
  logic        m_valid;
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic        m_fault;
  logic        m_fault_wait;
  logic [31:0] exp_pc;
  int          dut_fault_beats;

  ifetch_unit #(.WIDTH(32), .ILEN(32)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .pc          (pc),
    .pc_next     (pc_next),
    .pc_stall    (pc_stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .if_valid    (if_valid),
    .if_ready    (if_ready),
    .if_instr    (if_instr),
    .if_pc       (if_pc),
    .if_fault    (if_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // PC register owned by the environment
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) pc <= 32'h0;
    else if (!pc_stall) pc <= pc_next;
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h00000013;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive inputs, play memory, check outputs, advance the model.
  task automatic step(input logic rdy, input logic redir, input logic [31:0] rpc,
                      input int unsigned lat);
    logic        free;
    logic        aligned;
    logic        exp_req;
    logic        fault_ld;
    logic        accepted;
    logic [31:0] exp_addr;
    if_ready    = rdy;
    redirect    = redir;
    redirect_pc = rpc;
    imem_ack    = 1'b0;
    imem_rdata  = 32'h0;
    #1;
    free = !m_valid || rdy;
`ifdef IFETCH_ALIGN_CHECK_EN
    aligned = (pc[1:0] == 2'b00);
`else
    aligned = 1'b1;
`endif
    fault_ld = !busy && !m_fault_wait && free && !aligned && !redir;
    exp_req  = !m_fault_wait && (busy || (free && aligned));
    exp_addr = busy ? tx_addr : pc;
    check("imem_req", 32'(imem_req), 32'(exp_req));
    if (exp_req) check("imem_addr", imem_addr, exp_addr);
    if (imem_req) begin
      if (!busy) begin
        busy      = 1'b1;
        stale     = 1'b0;
        tx_addr   = imem_addr;
        wait_left = lat;
      end
      if (wait_left == 0) begin
        imem_ack   = 1'b1;
        imem_rdata = mem_word(tx_addr);
      end else begin
        wait_left--;
      end
    end
    #1;
    accepted = imem_ack && !redir && !stale;
    if (redir) begin
      check("redir_pc_next", pc_next, rpc);
      check("redir_stall", 32'(pc_stall), 32'd0);
    end else if (accepted) begin
      check("ack_pc_next", pc_next, pc + 32'd4);
      check("ack_stall", 32'(pc_stall), 32'd0);
    end else begin
      check("hold_pc_next", pc_next, pc);
      check("hold_stall", 32'(pc_stall), 32'd1);
    end
    check("if_valid", 32'(if_valid), 32'(m_valid));
    if (m_valid) begin
      check("if_pc", if_pc, m_pc);
      check("if_instr", if_instr, m_instr);
      check("if_fault", 32'(if_fault), 32'(m_fault));
    end
    if (if_valid && if_fault && rdy) dut_fault_beats++;
    if (imem_ack) busy = 1'b0;
    else if (redir && busy) stale = 1'b1;
    if (redir) begin
      m_valid      = 1'b0;
      m_fault_wait = 1'b0;
      exp_pc       = rpc;
    end else if (accepted) begin
      check("stream_pc", tx_addr, exp_pc);
      exp_pc  = exp_pc + 32'd4;
      m_valid = 1'b1;
      m_pc    = tx_addr;
      m_instr = mem_word(tx_addr);
      m_fault = 1'b0;
    end else if (fault_ld) begin
      m_valid      = 1'b1;
      m_pc         = pc;
      m_instr      = 32'h0;
      m_fault      = 1'b1;
      m_fault_wait = 1'b1;
    end else if (m_valid && rdy) begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0; n_errors = 0;
    busy = 0; stale = 0; tx_addr = 0; wait_left = 0;
    m_valid = 0; m_pc = 0; m_instr = 0; m_fault = 0; m_fault_wait = 0;
    exp_pc = 0; dut_fault_beats = 0;
    reset_n = 1'b0; if_ready = 0; redirect = 0; redirect_pc = 0;
    imem_ack = 0; imem_rdata = 0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_if_valid", 32'(if_valid), 32'd0);
    check("rst_if_instr", if_instr, 32'd0);
    check("rst_if_pc", if_pc, 32'd0);
    check("rst_if_fault", 32'(if_fault), 32'd0);
    check("rst_imem_req", 32'(imem_req), 32'd0);
    reset_n = 1'b1;

    // first fetch acknowledged in the first cycle out of reset
    step(1'b1, 1'b0, 32'h0, 0);
    check("t1_valid", 32'(if_valid), 32'd1);
    check("t1_instr", if_instr, 32'h00000013);
    check("t1_pc", if_pc, 32'h0);

    // zero-wait streaming
    for (int i = 1; i < 4; i++) begin
      step(1'b1, 1'b0, 32'h0, 0);
      check("t2_stream_pc", if_pc, 32'(i * 4));
    end

    // three wait states
    step(1'b1, 1'b0, 32'h0, 3);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h0, 0);
    check("t3_pc", if_pc, 32'h10);

    // decode back-pressure then resume
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0, 0);
    check("t4_held_instr", if_instr, mem_word(32'h10));
    step(1'b1, 1'b0, 32'h0, 0);
    check("t4_resume_pc", if_pc, 32'h14);

    // redirect while a request is outstanding
    step(1'b1, 1'b0, 32'h0, 3);
    step(1'b1, 1'b1, 32'h100, 0);
    step(1'b1, 1'b0, 32'h0, 0);
    step(1'b1, 1'b0, 32'h0, 0);
    check("t5_dropped", 32'(if_valid), 32'd0);
    step(1'b1, 1'b0, 32'h0, 0);
    check("t5_new_pc", if_pc, 32'h100);

    // random traffic
    for (int i = 0; i < 800; i++) begin
      logic        r_rdy;
      logic        r_redir;
      logic [31:0] r_pc;
      r_rdy   = ($urandom % 4) != 0;
      r_redir = ($urandom % 16) == 0;
      r_pc    = $urandom & 32'h0000FFFC;
      step(r_rdy, r_redir, r_pc, $urandom_range(0, 3));
    end

`ifdef IFETCH_ALIGN_CHECK_EN
    // misaligned target traps until redirected
    dut_fault_beats = 0;
    step(1'b1, 1'b1, 32'h6, 0);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 32'h0, 0);
    check("t6_fault_beats", 32'(dut_fault_beats), 32'd1);
    check("t6_stalled_pc", pc, 32'h6);
    step(1'b1, 1'b1, 32'h8, 0);
    step(1'b1, 1'b0, 32'h0, 0);
    check("t6_resume_pc", if_pc, 32'h8);
    check("t6_resume_fault", 32'(if_fault), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
